// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and defaults for the unified memory port arbiter
package mem_arb_pkg;

    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } arb_src_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data request ports, memory port and stall of the arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rdata, d_gnt, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rdata, d_gnt, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/mem_port_arbiter_timer.sv
// rtl/mem_port_arbiter_timer.sv - loadable down-counter that flags when it reaches zero
module arb_latency_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         start_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Decrement saturates so a stray enable can never wrap the count.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!start_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flags the cycle in which the count arrives at zero, not the cycle after.
    assign zero = (cnt_d == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory sequencer shared by instruction fetch and MEM-stage data
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              start_n,
    mem_port_arbiter_if.slave bus
);
    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_e        state_q;
    arb_state_e        state_d;
    arb_src_e          src_q;
    logic              we_q;
    logic [SC_W-1:0]   starve_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              accept;
    logic              pick_fetch;
    logic              lat_zero;
    logic              done;

    // Data belongs to the older instruction, so it wins unless fetch has waited too long.
    assign pick_fetch = bus.if_req && (!bus.d_req || (starve_q == SC_MAX));
    assign accept     = (state_q == IDLE) && (bus.if_req || bus.d_req);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (lat_zero) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!start_n) begin
            state_q  <= IDLE;
            src_q    <= FETCH;
            we_q     <= 1'b0;
            starve_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (pick_fetch) begin
                    src_q    <= FETCH;
                    we_q     <= 1'b0;
                    addr_q   <= bus.if_addr;
                    starve_q <= '0;
                end else begin
                    src_q   <= DATA;
                    we_q    <= bus.d_we;
                    addr_q  <= bus.d_addr;
                    wdata_q <= bus.d_wdata;
                    if (bus.if_req && (starve_q != SC_MAX)) begin
                        starve_q <= starve_q + 1'b1;
                    end
                end
            end
        end
    end

    arb_latency_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .start_n  (start_n),
        .load     (state_q == ISSUE),
        .load_val (LAT_LOAD),
        .dec      (state_q == WAIT),
        .zero     (lat_zero)
    );

    // Gating on start_n keeps grants and strobes quiet while reset is held mid-access.
    assign done          = (state_q == DONE) && start_n;
    assign bus.mem_en    = (state_q == ISSUE) && start_n;
    assign bus.mem_we    = bus.mem_en && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_gnt    = done && (src_q == FETCH);
    assign bus.d_gnt     = done && (src_q == DATA);
    assign bus.if_rdata  = bus.if_gnt ? bus.mem_rdata : '0;
    assign bus.d_rdata   = bus.d_gnt ? bus.mem_rdata : '0;
    assign bus.stall     = (bus.if_req && !bus.if_gnt) || (bus.d_req && !bus.d_gnt);

endmodule
